// File: rtl/spike_servo_driver.sv
// Spike-rate to servo PWM driver: counts spike rising edges per window, maps the
// rate to a clamped pulse width and drives a fixed-period PWM with period-aligned updates.
//
// state | meaning
// IDLE  | parked (en=0 or after reset); pwm low, period counter cleared
// HIGH  | pwm high for the first active-width cycles of the period
// LOW   | pwm low for the remainder of the period; reloads width at the wrap
module spike_servo_driver #(
  parameter int WINDOW_CYCLES = 100,
  parameter int PWM_PERIOD    = 200,
  parameter int MIN_PULSE     = 20,
  parameter int STEP          = 2,
  parameter int MAX_PULSE     = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        spike,
  output logic        pwm,
  output logic [7:0]  rate,
  output logic        rate_valid,
  output logic [15:0] pulse_width
);

  localparam int WCW = $clog2(WINDOW_CYCLES);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW_CYCLES - 1);
  localparam logic [15:0]    PER_LAST = 16'(PWM_PERIOD - 1);
  localparam logic [15:0]    MIN_W    = 16'(MIN_PULSE);
  localparam logic [31:0]    MAX_W32  = 32'(MAX_PULSE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // ---------------------------------------------------------------- rate window
  logic           spike_d;
  logic           edge_det;
  logic [WCW-1:0] win_cnt;
  logic [7:0]     cnt;
  logic           win_last;
  logic [8:0]     cnt_sum;
  logic [7:0]     cnt_sat;

  assign edge_det = spike & ~spike_d;
  assign win_last = (win_cnt == WIN_LAST);
  assign cnt_sum  = {1'b0, cnt} + {8'd0, edge_det};
  assign cnt_sat  = cnt_sum[8] ? 8'hff : cnt_sum[7:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      spike_d    <= 1'b0;
      win_cnt    <= '0;
      cnt        <= 8'd0;
      rate       <= 8'd0;
      rate_valid <= 1'b0;
    end else begin
      spike_d <= spike;
      if (!en) begin
        win_cnt    <= '0;
        cnt        <= 8'd0;
        rate_valid <= 1'b0;
      end else begin
        rate_valid <= win_last;
        if (win_last) begin
          win_cnt <= '0;
          cnt     <= 8'd0;
          rate    <= cnt_sat;
        end else begin
          win_cnt <= win_cnt + 1'b1;
          cnt     <= cnt_sat;
        end
      end
    end
  end

  // ---------------------------------------------------------------- width map
  // Wide intermediate so rate*STEP cannot wrap before the clamp.
  logic [31:0] width_raw;
  logic [15:0] width_map;

  assign width_raw = 32'(MIN_PULSE) + 32'(rate) * 32'(STEP);
  assign width_map = (width_raw > MAX_W32) ? 16'(MAX_PULSE) : width_raw[15:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      pulse_width <= MIN_W;
    end else if (en && rate_valid) begin
      pulse_width <= width_map;
    end
  end

  // ---------------------------------------------------------------- PWM FSM
  state_t      state, state_n;
  logic [15:0] p_cnt, p_cnt_n;
  logic [15:0] active, active_n;
  logic        pwm_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      p_cnt  <= 16'd0;
      active <= MIN_W;
      pwm    <= 1'b0;
    end else begin
      state  <= state_n;
      p_cnt  <= p_cnt_n;
      active <= active_n;
      pwm    <= pwm_n;
    end
  end

  always_comb begin
    state_n  = state;
    p_cnt_n  = p_cnt;
    active_n = active;
    if (!en) begin
      state_n = IDLE;
      p_cnt_n = 16'd0;
    end else begin
      case (state)
        IDLE: begin
          p_cnt_n  = 16'd0;
          active_n = pulse_width;
          state_n  = (pulse_width == 16'd0) ? LOW : HIGH;
        end
        HIGH: begin
          p_cnt_n = p_cnt + 16'd1;
          if (p_cnt == active - 16'd1) begin
            state_n = LOW;
          end
        end
        LOW: begin
          // The only point where a new width is accepted, so a period is never altered.
          if (p_cnt == PER_LAST) begin
            p_cnt_n  = 16'd0;
            active_n = pulse_width;
            state_n  = (pulse_width == 16'd0) ? LOW : HIGH;
          end else begin
            p_cnt_n = p_cnt + 16'd1;
          end
        end
        default: begin
          state_n = IDLE;
          p_cnt_n = 16'd0;
        end
      endcase
    end
    pwm_n = (state_n == HIGH);
  end

endmodule
